// File: rtl/pixel_arbiter_pkg.sv
// pixel_arbiter_pkg
// Shared definitions for the pixel arbiter: FSM state encoding, visible
// screen height and the off-screen test used by the optional clipping path.
package pixel_arbiter_pkg;

    typedef enum logic [1:0] {
        PA_WAIT_CLEAR = 2'd0,
        PA_IDLE       = 2'd1,
        PA_ISSUE      = 2'd2,
        PA_WAIT_DONE  = 2'd3
    } pa_state_e;

    localparam logic [7:0] SCREEN_HEIGHT = 8'd192;

    function automatic logic is_offscreen(input logic [7:0] y);
        return (y >= SCREEN_HEIGHT);
    endfunction

endpackage

// File: rtl/pixel_arbiter_if.sv
// pixel_arbiter_if
// Bundles the two requester handshakes and the pixel_writer port.
//   master : arbiter side (takes requests and writer status, drives acks and
//            the pixel write strobe/data)
//   slave  : requester / pixel_writer side
// Signals:
//   req0/req1, rgb0/x0/y0, rgb1/x1/y1 : requests with 8-bit pixel data
//   ack0/ack1                         : one-cycle capture acknowledge
//   clear_screen_done, pixel_wr_done  : pixel_writer status
//   pixel_en, pixel_rgb/x/y           : pixel write strobe and data
interface pixel_arbiter_if;
    logic       req0, req1;
    logic [7:0] rgb0, x0, y0;
    logic [7:0] rgb1, x1, y1;
    logic       ack0, ack1;
    logic       clear_screen_done;
    logic       pixel_wr_done;
    logic       pixel_en;
    logic [7:0] pixel_rgb, pixel_x, pixel_y;

    modport master (
        input  req0, req1, rgb0, x0, y0, rgb1, x1, y1,
        input  clear_screen_done, pixel_wr_done,
        output ack0, ack1, pixel_en, pixel_rgb, pixel_x, pixel_y
    );

    modport slave (
        output req0, req1, rgb0, x0, y0, rgb1, x1, y1,
        output clear_screen_done, pixel_wr_done,
        input  ack0, ack1, pixel_en, pixel_rgb, pixel_x, pixel_y
    );
endinterface

// File: rtl/pixel_arbiter_rr_arb2.sv
// rr_arb2
// Two-way arbiter: combinational pick plus a registered round-robin pointer.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   req0, req1   : requests
//   grant_en     : the pick is consumed this cycle (pointer advances)
//   valid        : at least one request present
//   winner       : 0 = req0 wins, 1 = req1 wins
// FIXED_PRIO = 1 makes req0 win whenever it is high.
module rr_arb2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic grant_en,
    output logic valid,
    output logic winner
);
    // Names the requester favoured when both ask; 0 after reset.
    logic ptr;

    always_comb begin
        valid  = req0 | req1;
        winner = ~req0;
        if (FIXED_PRIO == 0 && req0 && req1) begin
            winner = ptr;
        end
    end

    // After a grant the loser becomes the favoured requester.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (grant_en && valid) begin
            ptr <= ~winner;
        end
    end
endmodule

// File: rtl/pixel_arbiter.sv
// pixel_arbiter
// Shares the pixel_writer write port between the CPU graphics path (req0) and
// the blitter/sprite engine (req1). Nothing is granted until the power-up
// screen clear completes; each grant captures the winner's pixel, pulses
// pixel_en/ackN for one cycle and then waits for pixel_wr_done (or a timeout)
// before the next grant.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   bus         : pixel_arbiter_if.master (requests, acks, pixel_writer port)
//   busy        : high in every state except IDLE
//   stall_err   : sticky, a pixel write timed out
// Parameters: FIXED_PRIO (0 round-robin, 1 req0 wins), TIMEOUT (1..255).
// Build option: PIXEL_ARB_CLIP_EN - requests with y >= 192 are acked but
// not written.
//
// state         | meaning
// WAIT_CLEAR    | screen clear in progress, no grants
// IDLE          | ready, arbitrating requests
// ISSUE         | pixel_en/ack strobe cycle
// WAIT_DONE     | waiting for pixel_wr_done or timeout
module pixel_arbiter
    import pixel_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    pixel_arbiter_if.master bus,
    output logic            busy,
    output logic            stall_err
);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    pa_state_e  state;
    logic [7:0] tmo_cnt;
    logic       issue_clip;
    logic       arb_valid, arb_winner, grant_en, clip;
    logic [7:0] sel_rgb, sel_x, sel_y;

    assign grant_en = (state == PA_IDLE);

    rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (bus.req0),
        .req1     (bus.req1),
        .grant_en (grant_en),
        .valid    (arb_valid),
        .winner   (arb_winner)
    );

    assign sel_rgb = arb_winner ? bus.rgb1 : bus.rgb0;
    assign sel_x   = arb_winner ? bus.x1   : bus.x0;
    assign sel_y   = arb_winner ? bus.y1   : bus.y0;

`ifdef PIXEL_ARB_CLIP_EN
    assign clip = is_offscreen(sel_y);
`else
    assign clip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= PA_WAIT_CLEAR;
            busy          <= 1'b1;
            stall_err     <= 1'b0;
            tmo_cnt       <= 8'd0;
            issue_clip    <= 1'b0;
            bus.pixel_en  <= 1'b0;
            bus.ack0      <= 1'b0;
            bus.ack1      <= 1'b0;
            bus.pixel_rgb <= 8'd0;
            bus.pixel_x   <= 8'd0;
            bus.pixel_y   <= 8'd0;
        end else begin
            bus.pixel_en <= 1'b0;
            bus.ack0     <= 1'b0;
            bus.ack1     <= 1'b0;
            unique case (state)
                PA_WAIT_CLEAR: begin
                    if (bus.clear_screen_done) begin
                        state <= PA_IDLE;
                        busy  <= 1'b0;
                    end
                end
                PA_IDLE: begin
                    if (arb_valid) begin
                        bus.ack0   <= ~arb_winner;
                        bus.ack1   <= arb_winner;
                        state      <= PA_ISSUE;
                        busy       <= 1'b1;
                        issue_clip <= clip;
                        // A clipped request still spends the ack cycle in
                        // ISSUE so its held req is not granted twice.
                        if (!clip) begin
                            bus.pixel_en  <= 1'b1;
                            bus.pixel_rgb <= sel_rgb;
                            bus.pixel_x   <= sel_x;
                            bus.pixel_y   <= sel_y;
                        end
                    end
                end
                PA_ISSUE: begin
                    tmo_cnt <= 8'd0;
                    if (issue_clip) begin
                        state <= PA_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= PA_WAIT_DONE;
                    end
                end
                PA_WAIT_DONE: begin
                    if (bus.pixel_wr_done) begin
                        state <= PA_IDLE;
                        busy  <= 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        stall_err <= 1'b1;
                        state     <= PA_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_arbiter.sv
// tb_pixel_arbiter
// Round-robin instance (TIMEOUT = 10) driven by random requesters and a
// random pixel_writer done model, checked every cycle against a
// transaction/timing reference model. A second instance with FIXED_PRIO = 1
// gets a short directed run with both requesters saturated.
module tb_pixel_arbiter;
    localparam int TMO = 10;
    localparam int BIG = 32'h3fff_ffff;
`ifdef PIXEL_ARB_CLIP_EN
    localparam bit CLIP_ON = 1'b1;
`else
    localparam bit CLIP_ON = 1'b0;
`endif

    logic clk, rst_n;
    logic busy1, stall1, busy2, stall2;

    pixel_arbiter_if bus1 ();
    pixel_arbiter_if bus2 ();

    pixel_arbiter #(.FIXED_PRIO(0), .TIMEOUT(TMO)) dut_rr (
        .clk(clk), .rst_n(rst_n), .bus(bus1.master), .busy(busy1), .stall_err(stall1)
    );
    pixel_arbiter #(.FIXED_PRIO(1), .TIMEOUT(TMO)) dut_fp (
        .clk(clk), .rst_n(rst_n), .bus(bus2.master), .busy(busy2), .stall_err(stall2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle-time %0t: got %0h, expected %0h", tag, $time, obs, expv);
        end
    endtask

    // 0 hands-off, 1 random requests, 2 both requesters saturated
    int req_mode  = 0;
    // 0 never, 1 random 1..4 plus stray pulses, 3 stale level high,
    // 4 fixed 3 cycles, 5 manual
    int done_mode = 3;
    int done_cnt  = 0;
    bit ack0_q = 0, ack1_q = 0;

    // ---------------- reference model (dut_rr) ----------------
    int cyc = 0;
    bit mdl_ok = 0;
    int free_from = BIG;   // first cycle in which the arbiter is idle
    bit cleared = 0, open_wr = 0, ptr = 0;
    int g_cyc = 0;          // cycle in which the open write was strobed
    bit e_ack0 = 0, e_ack1 = 0, e_en = 0, e_stall = 0;
    logic [23:0] e_pix = 24'd0;

    initial begin : monitor
        bit w;
        logic [7:0] wy;
        forever begin
            @(negedge clk);
            cyc++;
            ack0_q = bus1.ack0;
            ack1_q = bus1.ack1;
            if (bus1.pixel_en) begin
                if (done_mode == 1)      done_cnt = $urandom_range(1, 4);
                else if (done_mode == 4) done_cnt = 3;
                else                     done_cnt = 0;
            end
            if (mdl_ok) begin
                chk("ack", {30'd0, bus1.ack1, bus1.ack0}, {30'd0, e_ack1, e_ack0});
                chk("pixel_en", {31'd0, bus1.pixel_en}, {31'd0, e_en});
                chk("pixel_data", {8'd0, bus1.pixel_rgb, bus1.pixel_x, bus1.pixel_y}, {8'd0, e_pix});
                chk("busy", {31'd0, busy1}, {31'd0, (cyc < free_from)});
                chk("stall_err", {31'd0, stall1}, {31'd0, e_stall});
            end
            e_ack0 = 0; e_ack1 = 0; e_en = 0;
            if (!rst_n) begin
                mdl_ok = 1; free_from = BIG; cleared = 0; open_wr = 0;
                ptr = 0; e_pix = 24'd0; e_stall = 0;
            end else if (mdl_ok) begin
                if (open_wr && cyc > g_cyc) begin
                    if (bus1.pixel_wr_done) begin
                        free_from = cyc + 1; open_wr = 0;
                    end else if (cyc == g_cyc + TMO) begin
                        free_from = cyc + 1; open_wr = 0; e_stall = 1;
                    end
                end
                if (!cleared && bus1.clear_screen_done) begin
                    cleared = 1; free_from = cyc + 1;
                end
                if (cyc >= free_from && (bus1.req0 || bus1.req1)) begin
                    if (bus1.req0 && bus1.req1) w = ptr;
                    else                        w = bus1.req1;
                    ptr = ~w;
                    if (w) e_ack1 = 1; else e_ack0 = 1;
                    wy = w ? bus1.y1 : bus1.y0;
                    if (CLIP_ON && wy >= 8'd192) begin
                        free_from = cyc + 2;
                    end else begin
                        e_en  = 1;
                        e_pix = w ? {bus1.rgb1, bus1.x1, bus1.y1} : {bus1.rgb0, bus1.x0, bus1.y0};
                        g_cyc = cyc + 1; open_wr = 1; free_from = BIG;
                    end
                end
            end
        end
    end

    // ---------------- stimulus generators (bus1) ----------------
    task automatic step_req(input int idx);
        bit cur, acked, go;
        if (req_mode == 0) return;
        cur   = (idx == 0) ? bus1.req0 : bus1.req1;
        acked = (idx == 0) ? ack0_q : ack1_q;
        if (cur && !acked) return;
        go = (req_mode == 2) || ($urandom_range(0, 2) == 0);
        if (idx == 0) begin
            bus1.req0 = go;
            if (go) begin
                bus1.rgb0 = 8'($urandom); bus1.x0 = 8'($urandom); bus1.y0 = 8'($urandom);
            end
        end else begin
            bus1.req1 = go;
            if (go) begin
                bus1.rgb1 = 8'($urandom); bus1.x1 = 8'($urandom); bus1.y1 = 8'($urandom);
            end
        end
    endtask

    initial begin : reqgen
        forever begin
            @(posedge clk);
            #1;
            step_req(0);
            step_req(1);
        end
    end

    initial begin : donegen
        forever begin
            @(posedge clk);
            #1;
            if (done_mode == 3) begin
                bus1.pixel_wr_done = 1'b1;
            end else if (done_mode != 5) begin
                bus1.pixel_wr_done = 1'b0;
                if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) bus1.pixel_wr_done = 1'b1;
                end else if (done_mode == 1 && $urandom_range(0, 9) == 0) begin
                    bus1.pixel_wr_done = 1'b1;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int n;
        bit got;
        logic [23:0] fp_exp;
        rst_n = 1'b0;
        bus1.req0 = 0; bus1.req1 = 0;
        bus1.rgb0 = 0; bus1.x0 = 0; bus1.y0 = 0;
        bus1.rgb1 = 0; bus1.x1 = 0; bus1.y1 = 0;
        bus1.clear_screen_done = 0; bus1.pixel_wr_done = 1;
        bus2.req0 = 0; bus2.req1 = 0;
        bus2.rgb0 = 0; bus2.x0 = 0; bus2.y0 = 0;
        bus2.rgb1 = 0; bus2.x1 = 0; bus2.y1 = 0;
        bus2.clear_screen_done = 1; bus2.pixel_wr_done = 0;

        cycles(3);
        rst_n = 1'b1;
        bus1.req0 = 1; bus1.rgb0 = 8'hE0; bus1.x0 = 8'h05; bus1.y0 = 8'h0A;
        cycles(50);
        chk("preclear_busy", {31'd0, busy1}, 32'd1);

        done_mode = 4;
        bus1.clear_screen_done = 1;
        n = 0;
        @(negedge clk);
        while (!bus1.pixel_en && n < 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("clear_to_en", n, 2);
        chk("first_pix", {8'd0, bus1.pixel_rgb, bus1.pixel_x, bus1.pixel_y}, 32'h00E0050A);
        chk("first_ack0", {31'd0, bus1.ack0}, 32'd1);
        @(posedge clk);
        #1;
        bus1.req0 = 0;
        cycles(10);

        done_mode = 1; req_mode = 1;
        cycles(600);
        req_mode = 2;
        cycles(200);
        req_mode = 1; done_mode = 0;
        cycles(200);
        chk("stall_sticky", {31'd0, stall1}, 32'd1);

        // reset during WAIT_DONE, then a late done pulse that must be ignored
        done_mode = 5; bus1.pixel_wr_done = 0;
        n = 0;
        @(negedge clk);
        while (!bus1.pixel_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_write_seen", {31'd0, bus1.pixel_en}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0; bus1.clear_screen_done = 0;
        @(posedge clk); #1;
        rst_n = 1; bus1.pixel_wr_done = 1;
        @(negedge clk);
        chk("rst_stall", {31'd0, stall1}, 32'd0);
        chk("rst_busy", {31'd0, busy1}, 32'd1);
        chk("rst_pix", {8'd0, bus1.pixel_rgb, bus1.pixel_x, bus1.pixel_y}, 32'd0);
        @(posedge clk); #1;
        bus1.pixel_wr_done = 0;
        cycles(20);
        bus1.clear_screen_done = 1; done_mode = 1;
        cycles(150);
        req_mode = 0;
        cycles(20);

        // fixed-priority instance: both requesters saturated
        bus2.req0 = 1; bus2.req1 = 1;
        bus2.rgb0 = 8'h11; bus2.x0 = 8'h22; bus2.y0 = 8'h33;
        bus2.rgb1 = 8'h44; bus2.x1 = 8'h55; bus2.y1 = 8'h66;
        for (int k = 0; k < 8; k++) begin
            got = 0; n = 0;
            fp_exp = {bus2.rgb0, bus2.x0, bus2.y0};
            while (!got && n < 20) begin
                @(negedge clk);
                if (bus2.ack0 || bus2.ack1) got = 1;
                n++;
            end
            chk("fp_ack_seen", {31'd0, got}, 32'd1);
            chk("fp_winner", {30'd0, bus2.ack1, bus2.ack0}, 32'd1);
            chk("fp_pix", {8'd0, bus2.pixel_rgb, bus2.pixel_x, bus2.pixel_y}, {8'd0, fp_exp});
            @(posedge clk); #1;
            bus2.rgb0 = 8'($urandom); bus2.x0 = 8'($urandom); bus2.y0 = 8'($urandom);
            @(posedge clk); #1;
            bus2.pixel_wr_done = 1;
            @(posedge clk); #1;
            bus2.pixel_wr_done = 0;
        end
        chk("fp_stall", {31'd0, stall2}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
